sdp_ram: RTL and testbench

SDP_RAM -- requirements
Module: sdp_ram

---
 rtl/sdp_ram_pkg.sv | 23 ++
 rtl/sdp_ram_rdpipe.sv | 63 ++++++
 rtl/sdp_ram.sv | 136 +++++++++++++
 tb/tb_sdp_ram.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// -----------------------------------------------------------------------------
// sdp_ram_pkg
// Shared definitions for the simple dual-port RAM slice:
//   - state_e        : controller states (ST_INIT = post-reset clear, ST_RUN)
//   - *_DEFAULT      : default DW / AW / RD_LAT parameter values
//   - RD_LAT_MIN/MAX : legal bounds of the read latency parameter
// Optional build macro used by the slice: SDP_RAM_FWD_EN (see sdp_ram.sv).
// -----------------------------------------------------------------------------
package sdp_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DW_DEFAULT     = 8;
  localparam int AW_DEFAULT     = 6;
  localparam int RD_LAT_DEFAULT = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/sdp_ram_rdpipe.sv
// -----------------------------------------------------------------------------
// sdp_ram_rdpipe
// Read-data / read-valid delay line of RD_LAT stages. The last stage is the
// registered output: dout only loads when a read completes, so it holds its
// previous value otherwise.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_vld, in_data   : read accepted this cycle and the word it returns
//   dout, dout_vld    : registered read data and its one-cycle valid pulse
// -----------------------------------------------------------------------------
module sdp_ram_rdpipe
  import sdp_ram_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  logic          last_vld;
  logic [DW-1:0] last_data;

  // Only RD_LAT of 1 or 2 is legal; latency 2 adds one unconditional stage
  // ahead of the output register.
  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    logic          vld_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q  <= in_vld;
        data_q <= in_data;
      end
    end

    assign last_vld  = vld_q;
    assign last_data = data_q;
  end else begin : g_lat1
    assign last_vld  = in_vld;
    assign last_data = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= last_vld;
      if (last_vld) begin
        dout <= last_data;
      end
    end
  end

endmodule

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM (one write port, one read port, single clock) with
// byte-lane write enables, a self-clearing memory after reset and a
// configurable read latency.
// Handshake: there is no back-pressure. In ST_RUN every cycle with wr_en=1 is
// a write and every cycle with rd_en=1 is a read; during ST_INIT (init_busy=1)
// both requests are dropped.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_be,   : write request, address, byte-lane enables
//   din                      :   and write data
//   rd_en, rd_addr           : read request and address
//   dout, dout_vld           : read data and its one-cycle valid pulse,
//                              RD_LAT cycles after the read is accepted
//   init_busy                : high while memory is being cleared
// Build macro: SDP_RAM_FWD_EN -- when defined, a read and write to the same
// address in the same cycle return the merged (newly written) word instead of
// the pre-write data.
// -----------------------------------------------------------------------------
module sdp_ram
  import sdp_ram_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   din,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  output logic            init_busy
);

  localparam int DEPTH = 2 ** AW;
  localparam int NB    = DW / 8;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic [DW-1:0] mem [DEPTH];

  logic          run;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_merged;
  logic [DW-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Controller: clear every address once after reset, then run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        // The counter wraps back to 0 on the last clear, leaving it parked.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);

  // ---------------------------------------------------------------------------
  // Write port. Byte enables are applied as a read-modify-write of the whole
  // word so the array has a single full-word write; the same merged word
  // feeds the optional forwarding path.
  // ---------------------------------------------------------------------------
  assign wr_old = mem[wr_addr];

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign wr_merged[8*b +: 8] = wr_be[b] ? din[8*b +: 8] : wr_old[8*b +: 8];
  end

  assign mem_we    = !rst && (!run || wr_en);
  assign mem_waddr = run ? wr_addr : clr_cnt_q;
  assign mem_wdata = run ? wr_merged : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. The array read happens before this edge's write lands, so a
  // same-address collision naturally returns the old word.
  // ---------------------------------------------------------------------------
`ifdef SDP_RAM_FWD_EN
  assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_merged : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif

  sdp_ram_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (run && rd_en),
    .in_data  (rd_word),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

endmodule

// File: tb/tb_sdp_ram.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram
// Bench for sdp_ram. Two instances share one stimulus stream: u_dut_a with
// RD_LAT=2 and u_dut_b with RD_LAT=1, both DW=32, AW=6. A behavioural memory
// model predicts init_busy, dout and dout_vld for both instances every cycle;
// directed sequences add literal expectations for clear, byte enables,
// latency, collisions, wrap address and reset during clear/read.
// -----------------------------------------------------------------------------
module tb_sdp_ram;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] dout_a, dout_b;
  logic          dout_vld_a, dout_vld_b;
  logic          init_busy_a, init_busy_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sdp_ram #(.DW(DW), .AW(AW), .RD_LAT(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .din       (din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .dout      (dout_a),
    .dout_vld  (dout_vld_a),
    .init_busy (init_busy_a)
  );

  sdp_ram #(.DW(DW), .AW(AW), .RD_LAT(1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .din       (din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .dout      (dout_b),
    .dout_vld  (dout_vld_b),
    .init_busy (init_busy_b)
  );

  // ---------------------------------------------------------------------------
  // Counters and comparison helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a word array, a count of clear cycles still to run,
  // and per-instance queues of read results with the edge they are due on.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = 0;
  int            edge_n     = 0;
  bit            model_live = 1'b0;

  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];
  int            due_q_a[$];
  int            due_q_b[$];

  logic [DW-1:0] exp_dout_a = '0, exp_dout_b = '0;
  logic          exp_vld_a  = 1'b0, exp_vld_b = 1'b0;

  initial begin
    logic [DW-1:0] merged;
    logic [DW-1:0] rv;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        model_live = 1'b1;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q_a.delete();
        exp_q_b.delete();
        due_q_a.delete();
        due_q_b.delete();
        exp_dout_a = '0;
        exp_dout_b = '0;
        exp_vld_a  = 1'b0;
        exp_vld_b  = 1'b0;
      end else begin
        if (clear_left > 0) begin
          clear_left--;
        end else begin
          merged = ref_mem[wr_addr];
          for (int i = 0; i < NB; i++)
            if (wr_be[i]) merged[8*i +: 8] = din[8*i +: 8];
          if (rd_en) begin
            rv = ref_mem[rd_addr];
`ifdef SDP_RAM_FWD_EN
            if (wr_en && (wr_addr == rd_addr)) rv = merged;
`endif
            exp_q_a.push_back(rv);
            due_q_a.push_back(edge_n + 1);
            exp_q_b.push_back(rv);
            due_q_b.push_back(edge_n);
          end
          if (wr_en) ref_mem[wr_addr] = merged;
        end
        exp_vld_a = 1'b0;
        if (due_q_a.size() > 0 && due_q_a[0] == edge_n) begin
          exp_vld_a  = 1'b1;
          exp_dout_a = exp_q_a.pop_front();
          void'(due_q_a.pop_front());
        end
        exp_vld_b = 1'b0;
        if (due_q_b.size() > 0 && due_q_b[0] == edge_n) begin
          exp_vld_b  = 1'b1;
          exp_dout_b = exp_q_b.pop_front();
          void'(due_q_b.pop_front());
        end
      end
    end
  end

  // Scoreboard compare, every cycle once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("busy_a", init_busy_a, clear_left > 0);
        check("busy_b", init_busy_b, clear_left > 0);
        check("vld_a",  dout_vld_a,  exp_vld_a);
        check("vld_b",  dout_vld_b,  exp_vld_b);
        check("dout_a", dout_a,      exp_dout_a);
        check("dout_b", dout_b,      exp_dout_b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; din = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Single read; checks the RD_LAT=1 instance after one edge and the
  // RD_LAT=2 instance after two.
  task automatic read_lit(input string name, input logic [AW-1:0] a,
                          input logic [DW-1:0] want);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    check({name, "_vld_b"}, dout_vld_b, 1);
    check({name, "_b"},     dout_b,     want);
    @(negedge clk);
    check({name, "_vld_a"}, dout_vld_a, 1);
    check({name, "_a"},     dout_a,     want);
  endtask

  // Runs from the moment rst is released, driving random requests, and
  // returns how many cycles init_busy stayed high (bounded).
  task automatic run_clear(input int max_cycles, output int busy_len,
                           output bit saw_vld);
    busy_len = 0;
    saw_vld  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!init_busy_a || busy_len == max_cycles) break;
      busy_len++;
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_be   = NB'($urandom_range(0, 15));
      din     = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      if (dout_vld_a || dout_vld_b) saw_vld = 1'b1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int       busy_len;
    bit       saw_vld;
    logic [DW-1:0] col_want;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; din = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", init_busy_a, 1);
    check("rst_vld",  dout_vld_a,  0);
    check("rst_dout", dout_a,      0);

    // Clear with requests driven throughout
    rst = 1'b0;
    run_clear(200, busy_len, saw_vld);
    check("clear_len", busy_len, 64);
    check("clear_vld", saw_vld,  0);

    // Memory is zero after the clear
    read_lit("zero0", 6'd0, 32'h0);
    read_lit("zero63", 6'd63, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      @(negedge clk);
    end
    rd_en = 1'b0;
    repeat (2) @(negedge clk);

    // Byte enables
    write_word(6'd5, 32'h11223344, 4'hF);
    write_word(6'd5, 32'hAABBCCDD, 4'b0101);
    read_lit("be", 6'd5, 32'h11BB33DD);
    write_word(6'd5, 32'hFFFFFFFF, 4'b0000);
    read_lit("be0", 6'd5, 32'h11BB33DD);

    // Top address
    write_word(6'd63, 32'hCAFEF00D, 4'hF);
    read_lit("top", 6'd63, 32'hCAFEF00D);

    // Back-to-back reads, full throughput
    write_word(6'd1, 32'h01010101, 4'hF);
    write_word(6'd2, 32'h02020202, 4'hF);
    write_word(6'd3, 32'h03030303, 4'hF);
    rd_en = 1'b1; rd_addr = 6'd1;
    @(negedge clk);
    check("lat_b1", dout_b, 32'h01010101);
    check("lat_a_early", dout_vld_a, 0);
    rd_addr = 6'd2;
    @(negedge clk);
    check("lat_b2", dout_b, 32'h02020202);
    check("lat_a1_vld", dout_vld_a, 1);
    check("lat_a1", dout_a, 32'h01010101);
    rd_addr = 6'd3;
    @(negedge clk);
    rd_en = 1'b0;
    check("lat_a2_vld", dout_vld_a, 1);
    check("lat_a2", dout_a, 32'h02020202);
    @(negedge clk);
    check("lat_a3_vld", dout_vld_a, 1);
    check("lat_a3", dout_a, 32'h03030303);
    @(negedge clk);
    check("lat_a_end", dout_vld_a, 0);
    check("lat_hold", dout_a, 32'h03030303);

    // Same-address collision at address 9 (still zero)
`ifdef SDP_RAM_FWD_EN
    col_want = 32'h0000005A;
`else
    col_want = 32'h00000000;
`endif
    wr_en = 1'b1; wr_addr = 6'd9; din = 32'h0000005A; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'd9;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("col_b", dout_b, col_want);
    @(negedge clk);
    check("col_a", dout_a, col_want);
    read_lit("col_after", 6'd9, 32'h0000005A);

    // Random traffic over a small address window to force collisions
    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7));
      wr_be   = NB'($urandom_range(0, 15));
      din     = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 7));
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset with a read in flight
    rd_en = 1'b1; rd_addr = 6'd5;
    @(negedge clk);
    rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_read_vld_a", dout_vld_a, 0);
    check("rst_read_dout_a", dout_a, 0);

    // Reset again at clear cycle 30
    rst = 1'b0;
    run_clear(30, busy_len, saw_vld);
    check("mid_clear_len", busy_len, 30);
    check("mid_clear_vld", saw_vld, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_clear(200, busy_len, saw_vld);
    check("reclear_len", busy_len, 64);
    check("reclear_vld", saw_vld, 0);
    read_lit("reclear5", 6'd5, 32'h0);
    read_lit("reclear9", 6'd9, 32'h0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
